hid_report_tx_queue: RTL and testbench
======================================

Name: hid_report_tx_queue

Overview:
Downstream consumer of the 1 kHz HID report engine. Captures each 8-byte report on its one-cycle valid strobe and queues it in a small report FIFO. Serializes queued reports byte-by-byte onto a valid/ready byte stream that feeds the USB endpoint buffer. Upstream has no backpressure, so the block absorbs endpoint stalls and counts any reports it drops.

Parameters:
DEPTH, 4, report FIFO depth in whole reports; power of 2, minimum 2.
CNT_W, 16, width of the drop and CRC-error counters.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  one-cycle strobe; in_report holds a complete report.
in_report  input  64  report bytes; byte k at [8k+7:8k] (byte0 = buttons … byte7 = reserved).
out_data  output  8  current stream byte.
out_valid  output  1  out_data is valid.
out_ready  input  1  endpoint accepts the byte this cycle.
out_last  output  1  high with byte 7 of each report.
fifo_level  output  $clog2(DEPTH)+1  reports held in the FIFO, excluding the one being serialized.
drop_count  output  CNT_W  reports lost to overflow; saturating.
crc_err_count  output  CNT_W  reports failing the CRC check; saturating; constant 0 when the check is compiled out.

Behaviour:
- Reset: every output is 0, the FIFO is empty, counters are 0, the FSM is in IDLE. Reset is synchronous and active-high on clk.
- Reset mid-report: flush the FIFO and shift register. out_valid is 0 on the cycle after rst is sampled, and the partial report is never resumed.
- Write side: on in_valid, push in_report if the slot is available. Otherwise discard it and increment drop_count.
- Full test: evaluate full against occupancy after any same-cycle pop. A push that coincides with the serializer loading a new report from a full FIFO is accepted.
- Capacity: DEPTH reports in the FIFO plus 1 report in the shift register.
- FSM state IDLE: out_valid = 0. If the FIFO is not empty, pop the head into the 64-bit shift register, set byte_idx = 0 and go to SEND. Register out_valid so it rises the next cycle.
- FSM state SEND: out_valid = 1, out_data = byte[byte_idx], out_last = (byte_idx == 7).
  - Handshake occurs only when out_valid & out_ready in the same cycle.
  - On a handshake with byte_idx < 7: increment byte_idx.
  - On a handshake with byte_idx == 7: if the FIFO is non-empty, load the next report in the same cycle with no bubble and stay in SEND. Otherwise go to IDLE.
  - With out_valid high and out_ready low, out_data and out_last hold stable. out_valid never drops mid-report.
- Latency: in_valid at cycle N into an idle, empty block gives the FIFO write at N, the load at N+1, and out_valid with byte0 at N+2.
- Order: strictly FIFO; bytes go out 0..7 in order.
- fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- Counters saturate at all-ones and never wrap.

Optional Feature:
- Macro: HID_CRC_CHECK_EN.
- When defined:
  - On push, recompute CRC8 over bytes 0..5: polynomial 0x07, init 0x00, MSB-first, byte0 first.
  - Compare the result against byte6.
  - On mismatch, do not queue the report, increment crc_err_count and do not touch drop_count.
  - The check is combinational on in_report, so write latency is unchanged.
- When undefined: every report is queued regardless of byte6, and crc_err_count is tied to 0.

Test Plan:
- Single report, always-ready sink: in_report = 0x0000_0003_0000_0000, in_valid at cycle 10, out_ready = 1 → out_valid at cycle 12; 8 bytes 00,00,00,00,03,00,00,00 on consecutive cycles; out_last only on the 8th byte; IDLE afterwards.
- Backpressure: out_ready low on bytes 2–4 of a report for 5 cycles → out_data holds byte2 value, out_valid stays 1, no byte is duplicated or skipped; total of 8 handshakes.
- Overflow with DEPTH = 4, out_ready = 0: 7 strobes of reports 1..7 → reports 1..5 held (fifo_level = 4) and drop_count = 2; then release out_ready → stream carries reports 1..5 back-to-back with no idle cycle between out_last and the next byte0.
- Push while full concurrent with a load: push on the cycle the last byte of the current report handshakes with the FIFO full → report accepted, drop_count unchanged.
- CRC with HID_CRC_CHECK_EN: all-zero report (CRC = 0x00) → queued; the same report with byte6 = 0x01 → not queued, crc_err_count = 1. Without the macro, both are queued and crc_err_count = 0.
- Reset mid-report: assert rst during byte3 of a report with 2 more reports queued → out_valid = 0 next cycle, fifo_level = 0, counters 0. No stale bytes after reset is released.

Source files
------------

// File: rtl/hid_report_tx_queue.sv
// HID report transmit queue: captures 8-byte reports into a small FIFO and streams them
// byte-by-byte on a valid/ready interface. Define HID_CRC_CHECK_EN to reject reports whose byte6 CRC8 is wrong.
module hid_report_tx_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [63:0]              in_report,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         crc_err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [63:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [63:0]      sh_q, sh_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             send, hs, last_hs, empty, pop, push, crc_ok, space;
  logic [LW-1:0]    occ_after;

`ifdef HID_CRC_CHECK_EN
  logic [CNT_W-1:0] crc_err_q, crc_err_d;

  // CRC8, poly 0x07, init 0, MSB-first over bytes 0..5 with byte0 first.
  function automatic logic [7:0] crc8(input logic [47:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 0; b < 6; b++) begin
      c = c ^ d[8*b +: 8];
      for (int k = 0; k < 8; k++)
        c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_ok = (crc8(in_report[47:0]) == in_report[55:48]);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    send      = (state_q == S_SEND);
    hs        = send & out_ready;
    last_hs   = hs & (idx_q == 3'd7);
    empty     = (count_q == '0);
    pop       = !empty & (!send | last_hs);
    // Full is judged after this cycle's pop so a push racing a load is kept.
    occ_after = count_q - LW'(pop);
    space     = (occ_after < LW'(DEPTH));
    push      = in_valid & crc_ok & space;

    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = occ_after + LW'(push);

    drop_d    = drop_q;
    if (in_valid && crc_ok && !space && drop_q != '1)
      drop_d = drop_q + CNT_W'(1);

`ifdef HID_CRC_CHECK_EN
    crc_err_d = crc_err_q;
    if (in_valid && !crc_ok && crc_err_q != '1)
      crc_err_d = crc_err_q + CNT_W'(1);
`endif

    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    if (pop) begin
      sh_d    = mem_q[rd_ptr_q];
      idx_d   = 3'd0;
      state_d = S_SEND;
    end else if (last_hs) begin
      sh_d    = {8'h00, sh_q[63:8]};
      idx_d   = 3'd0;
      state_d = S_IDLE;
    end else if (hs) begin
      sh_d    = {8'h00, sh_q[63:8]};
      idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_report;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      sh_q     <= '0;
      idx_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      drop_q   <= drop_d;
    end
  end

`ifdef HID_CRC_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) crc_err_q <= '0;
    else     crc_err_q <= crc_err_d;
  end
  assign crc_err_count = crc_err_q;
`else
  assign crc_err_count = '0;
`endif

  // The shift register drains to zero, so out_data reads 0 whenever idle.
  assign out_data   = sh_q[7:0];
  assign out_valid  = send;
  assign out_last   = send & (idx_q == 3'd7);
  assign fifo_level = count_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_hid_report_tx_queue.sv
// Bench for hid_report_tx_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_hid_report_tx_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, out_ready;
  logic [63:0]      in_report;
  logic [7:0]       out_data;
  logic             out_valid, out_last;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] drop_count, crc_err_count;

  int tests = 0;
  int fails = 0;

  logic [63:0] mq[$];
  logic [63:0] m_cur;
  int          m_idx, m_drop, m_crc;
  bit          m_busy;

  hid_report_tx_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_report(in_report),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .fifo_level(fifo_level), .drop_count(drop_count), .crc_err_count(crc_err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // CRC as the remainder of (message * x^8) mod x^8+x^2+x+1, message = byte0..byte5 big-endian.
  function automatic logic [7:0] ref_crc(logic [63:0] r);
    logic [55:0] m;
    m = '0;
    for (int b = 0; b < 6; b++) m[55 - 8*b -: 8] = r[8*b +: 8];
    for (int i = 55; i >= 8; i--)
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    return m[7:0];
  endfunction

  function automatic logic [63:0] fix_crc(logic [63:0] r);
    logic [63:0] t;
    t = r;
    t[55:48] = ref_crc(r);
    return t;
  endfunction

  function automatic bit crc_good(logic [63:0] r);
`ifdef HID_CRC_CHECK_EN
    return ref_crc(r) == r[55:48];
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit hs, done, pop;
    logic [63:0] head;
    if (rst) begin
      mq.delete(); m_busy = 0; m_idx = 0; m_cur = '0; m_drop = 0; m_crc = 0;
      return;
    end
    hs   = m_busy && out_ready;
    done = hs && (m_idx == 7);
    pop  = (mq.size() > 0) && (!m_busy || done);
    head = '0;
    if (pop) head = mq.pop_front();
    if (in_valid) begin
      if (!crc_good(in_report)) m_crc = (m_crc < CMAX) ? m_crc + 1 : CMAX;
      else if (mq.size() < DEPTH) mq.push_back(in_report);
      else m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
    end
    if (pop) begin m_cur = head; m_idx = 0; m_busy = 1; end
    else if (done) m_busy = 0;
    else if (hs) m_idx++;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_busy));
    chk("out_last", 64'(out_last), 64'(m_busy && m_idx == 7));
    if (m_busy) chk("out_data", 64'(out_data), 64'(m_cur[8*m_idx +: 8]));
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("crc_err_count", 64'(crc_err_count), 64'(m_crc));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [7:0]  exp_b [8];
    logic [63:0] rep, got;
    logic [7:0]  bytes[$];
    int          nhs, d0, c0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_report = '0;
    @(negedge clk);
    repeat (3) cycle();
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_last", 64'(out_last), 64'h0);
    chk("rst_level", 64'(fifo_level), 64'h0);
    chk("rst_drop", 64'(drop_count), 64'h0);
    chk("rst_crc", 64'(crc_err_count), 64'h0);
    rst = 1'b0;
    repeat (6) cycle();

    // Single report, always-ready sink: two-cycle latency, then 8 bytes back to back.
    in_valid = 1'b1; in_report = 64'h0000_0003_0000_0000;
    cycle();
    in_valid = 1'b0;
    chk("lat_n1_valid", 64'(out_valid), 64'h0);
    cycle();
    chk("lat_n2_valid", 64'(out_valid), 64'h1);
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      chk("single_byte", 64'(out_data), 64'(exp_b[i]));
      chk("single_last", 64'(out_last), 64'(i == 7));
      cycle();
    end
    chk("single_idle", 64'(out_valid), 64'h0);

    // Backpressure on byte2 for five cycles.
    rep = fix_crc({$urandom, $urandom});
    in_valid = 1'b1; in_report = rep;
    cycle();
    in_valid = 1'b0;
    cycle();
    got = '0; nhs = 0;
    repeat (2) begin got[8*nhs +: 8] = out_data; nhs++; cycle(); end
    out_ready = 1'b0;
    repeat (5) begin
      chk("bp_hold_data", 64'(out_data), 64'(rep[23:16]));
      chk("bp_hold_valid", 64'(out_valid), 64'h1);
      cycle();
    end
    out_ready = 1'b1;
    for (int g = 0; g < 20 && out_valid; g++) begin
      if (nhs < 8) got[8*nhs +: 8] = out_data;
      nhs++;
      cycle();
    end
    chk("bp_handshakes", 64'(nhs), 64'd8);
    chk("bp_report", got, rep);

    // Overflow: 7 back-to-back strobes into a stalled sink.
    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      in_valid = 1'b1; in_report = fix_crc(64'(k));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_drop", 64'(drop_count), 64'd2);
    out_ready = 1'b1;
    bytes.delete();
    for (int g = 0; g < 40; g++) begin
      chk("ovf_no_bubble", 64'(out_valid), 64'h1);
      bytes.push_back(out_data);
      cycle();
    end
    chk("ovf_drained", 64'(out_valid), 64'h0);
    for (int r = 0; r < 5; r++) begin
      got = '0;
      for (int b = 0; b < 8; b++) got[8*b +: 8] = bytes[8*r + b];
      chk("ovf_order", got, fix_crc(64'(r + 1)));
    end

    // Push while full on the cycle the last byte handshakes and the next report loads.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_report = fix_crc({$urandom, $urandom});
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("full_level", 64'(fifo_level), 64'd4);
    d0 = m_drop;
    out_ready = 1'b1;
    for (int g = 0; g < 12 && !out_last; g++) cycle();
    chk("full_at_last", 64'(out_last), 64'h1);
    in_valid = 1'b1; in_report = fix_crc({$urandom, $urandom});
    cycle();
    in_valid = 1'b0;
    chk("full_drop_same", 64'(drop_count), 64'(d0));
    chk("full_level_kept", 64'(fifo_level), 64'd4);
    for (int g = 0; g < 60 && (out_valid || fifo_level != 0); g++) cycle();
    chk("full_drained", 64'(out_valid), 64'h0);

    // CRC check: all-zero report is valid, byte6 = 1 is not.
    c0 = m_crc;
    in_valid = 1'b1; in_report = 64'h0;
    cycle();
    in_report = 64'h0001_0000_0000_0000;
    cycle();
    in_valid = 1'b0;
    cycle();
`ifdef HID_CRC_CHECK_EN
    chk("crc_err_inc", 64'(crc_err_count), 64'(c0 + 1));
`else
    chk("crc_err_zero", 64'(crc_err_count), 64'h0);
`endif
    repeat (30) cycle();

    // Random traffic.
    for (int g = 0; g < 1500; g++) begin
      in_valid  = ($urandom_range(2) == 0);
      out_ready = ($urandom_range(3) != 0) ^ (g[8] & ($urandom_range(1) == 0));
      rep = {$urandom, $urandom};
      in_report = ($urandom_range(3) != 0) ? fix_crc(rep) : rep;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (60) cycle();

    // Reset during byte3 with two reports queued.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_report = fix_crc({$urandom, $urandom});
      cycle();
    end
    in_valid = 1'b0;
    for (int g = 0; g < 12 && !(m_busy && m_idx == 3); g++) cycle();
    chk("mid_level", 64'(fifo_level), 64'd2);
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_level", 64'(fifo_level), 64'h0);
    chk("mid_rst_drop", 64'(drop_count), 64'h0);
    chk("mid_rst_crc", 64'(crc_err_count), 64'h0);
    rst = 1'b0;
    repeat (20) begin
      cycle();
      chk("post_rst_quiet", 64'(out_valid), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
